// File: rtl/alarm_ringer_ctrl_pkg.sv
// rtl/alarm_ringer_ctrl_pkg.sv - shared alarm-ringer states, default timing constants and counter widths
package alarm_ringer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } ring_state_e;

    localparam int DEF_SNOOZE_MINS       = 5;
    localparam int DEF_RING_TIMEOUT_MINS = 10;
    localparam int DEF_MAX_SNOOZES       = 3;

    localparam int MIN_CNT_W    = 4;
    localparam int SNOOZE_CNT_W = 3;

endpackage

// File: rtl/alarm_edge_detect.sv
// rtl/alarm_edge_detect.sv - rising-edge detector for the comparator match level
module alarm_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    // Resets high so a match already present when reset releases is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/alarm_ringer_ctrl.sv
// rtl/alarm_ringer_ctrl.sv - alarm session controller (ring/snooze/stop/timeout); ALARM_BEEP_PATTERN_EN gates ring with a 1 s beep
module alarm_ringer_ctrl
    import alarm_ringer_ctrl_pkg::*;
#(
    parameter int SNOOZE_MINS       = DEF_SNOOZE_MINS,
    parameter int RING_TIMEOUT_MINS = DEF_RING_TIMEOUT_MINS,
    parameter int MAX_SNOOZES       = DEF_MAX_SNOOZES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alarm_on,
    input  logic                    RINGER1,
    input  logic                    min_tick,
    input  logic                    sec_tick,
    input  logic                    snooze,
    input  logic                    stop,
    output logic                    ring,
    output logic                    snoozing,
    output logic [SNOOZE_CNT_W-1:0] snooze_cnt
);

    localparam logic [MIN_CNT_W-1:0]    SNOOZE_LOAD = MIN_CNT_W'(SNOOZE_MINS);
    localparam logic [MIN_CNT_W-1:0]    TIMEOUT_CNT = MIN_CNT_W'(RING_TIMEOUT_MINS);
    localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_MAX  = SNOOZE_CNT_W'(MAX_SNOOZES);
    localparam logic [MIN_CNT_W-1:0]    MIN_ONE     = MIN_CNT_W'(1);

    ring_state_e             state, state_n;
    logic [MIN_CNT_W-1:0]    min_cnt, min_n;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_n;
    logic                    match_rise;
    logic                    ring_n;

    alarm_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (RINGER1),
        .rise  (match_rise)
    );

    always_comb begin
        state_n      = state;
        min_n        = min_cnt;
        snooze_cnt_n = snooze_cnt;
        if (!alarm_on) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match_rise) begin
                        state_n      = ST_RINGING;
                        min_n        = '0;
                        snooze_cnt_n = '0;
                    end
                end
                ST_RINGING: begin
                    // An exhausted snooze is treated as absent, so a coincident tick still counts.
                    if (stop) begin
                        state_n = ST_IDLE;
                    end else if (snooze && (snooze_cnt < SNOOZE_MAX)) begin
                        state_n      = ST_SNOOZE;
                        min_n        = SNOOZE_LOAD;
                        snooze_cnt_n = snooze_cnt + SNOOZE_CNT_W'(1);
                    end else if (min_tick) begin
                        min_n = min_cnt + MIN_ONE;
                        if (min_n == TIMEOUT_CNT) begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_n = ST_IDLE;
                    end else if (min_tick) begin
                        if (min_cnt == MIN_ONE) begin
                            state_n = ST_RINGING;
                            min_n   = '0;
                        end else begin
                            min_n = min_cnt - MIN_ONE;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_phase, beep_n;

    always_comb begin
        beep_n = beep_phase;
        if (state_n == ST_RINGING) begin
            if (state != ST_RINGING) begin
                beep_n = 1'b1;
            end else if (sec_tick) begin
                beep_n = ~beep_phase;
            end
        end
        ring_n = (state_n == ST_RINGING) & beep_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beep_phase <= 1'b0;
        end else begin
            beep_phase <= beep_n;
        end
    end
`else
    logic unused_sec_tick;

    assign unused_sec_tick = sec_tick;

    always_comb begin
        ring_n = (state_n == ST_RINGING);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            min_cnt    <= '0;
            snooze_cnt <= '0;
            ring       <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_n;
            min_cnt    <= min_n;
            snooze_cnt <= snooze_cnt_n;
            ring       <= ring_n;
            snoozing   <= (state_n == ST_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ringer_ctrl.sv
// tb/tb_alarm_ringer_ctrl.sv - directed and randomized checks of alarm_ringer_ctrl against a session-level model
module tb_alarm_ringer_ctrl;

    localparam int SNOOZE_MINS       = 5;
    localparam int RING_TIMEOUT_MINS = 10;
    localparam int MAX_SNOOZES       = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_on, RINGER1, min_tick, sec_tick, snooze, stop;
    logic       ring, snoozing;
    logic [2:0] snooze_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic cur_a, cur_r;

    // Session model: 0 = quiet, 1 = ringing, 2 = snoozed; timers count minutes remaining.
    int m_mode, m_ring_left, m_snooze_left, m_snoozes;
    bit m_prev_match, m_beep;

    alarm_ringer_ctrl #(
        .SNOOZE_MINS       (SNOOZE_MINS),
        .RING_TIMEOUT_MINS (RING_TIMEOUT_MINS),
        .MAX_SNOOZES       (MAX_SNOOZES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alarm_on   (alarm_on),
        .RINGER1    (RINGER1),
        .min_tick   (min_tick),
        .sec_tick   (sec_tick),
        .snooze     (snooze),
        .stop       (stop),
        .ring       (ring),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit a, input bit r, input bit mt, input bit st,
                                input bit sn, input bit sp);
        bit rise;
        int was;
        rise = r && !m_prev_match;
        m_prev_match = r;
        was = m_mode;
        if (!a) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (rise) begin
                m_mode = 1;
                m_ring_left = RING_TIMEOUT_MINS;
                m_snoozes = 0;
            end
        end else if (m_mode == 1) begin
            if (sp) begin
                m_mode = 0;
            end else if (sn && m_snoozes < MAX_SNOOZES) begin
                m_mode = 2;
                m_snooze_left = SNOOZE_MINS;
                m_snoozes++;
            end else if (mt) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 0;
            end
        end else begin
            if (sp) begin
                m_mode = 0;
            end else if (mt) begin
                m_snooze_left--;
                if (m_snooze_left == 0) begin
                    m_mode = 1;
                    m_ring_left = RING_TIMEOUT_MINS;
                end
            end
        end
        if (m_mode == 1) begin
            if (was != 1) m_beep = 1'b1;
            else if (st) m_beep = !m_beep;
        end
    endtask

    function automatic logic exp_ring();
`ifdef ALARM_BEEP_PATTERN_EN
        return (m_mode == 1) && m_beep;
`else
        return (m_mode == 1);
`endif
    endfunction

    task automatic step(input bit mt, input bit st, input bit sn, input bit sp);
        alarm_on = cur_a;
        RINGER1  = cur_r;
        min_tick = mt;
        sec_tick = st;
        snooze   = sn;
        stop     = sp;
        @(posedge clk);
        model_update(cur_a, cur_r, mt, st, sn, sp);
        #1;
        check("ring", {3'b0, ring}, {3'b0, exp_ring()});
        check("snoozing", {3'b0, snoozing}, {3'b0, logic'(m_mode == 2)});
        check("snooze_cnt", {1'b0, snooze_cnt}, 4'(m_snoozes));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cur_a = 1'b1;
        cur_r = 1'b1;
        alarm_on = 1'b1; RINGER1 = 1'b1;
        min_tick = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
        m_mode = 0; m_ring_left = 0; m_snooze_left = 0; m_snoozes = 0;
        m_prev_match = 1'b1; m_beep = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ring", {3'b0, ring}, 4'd0);
        check("reset_snoozing", {3'b0, snoozing}, 4'd0);
        check("reset_snooze_cnt", {1'b0, snooze_cnt}, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // Match already high at reset release must not fire.
        idle(3);
        check("no_fire_at_release", {3'b0, ring}, 4'd0);

        // Fresh rise: ring one cycle after the rise cycle.
        cur_r = 1'b0; idle(2);
        cur_r = 1'b1; step(0, 0, 0, 0);
        check("ring_latency", {3'b0, ring}, 4'd1);

        step(0, 0, 1, 0);
        check("snooze_ring_off", {3'b0, ring}, 4'd0);
        check("snooze_flag", {3'b0, snoozing}, 4'd1);
        check("snooze_cnt_1", {1'b0, snooze_cnt}, 4'd1);
        for (int i = 0; i < SNOOZE_MINS - 1; i++) begin
            step(1, 0, 0, 0);
            idle(2);
        end
        check("still_snoozed", {3'b0, ring}, 4'd0);
        step(1, 0, 0, 0);
        check("rering_after_snooze", {3'b0, ring}, 4'd1);

        for (int k = 0; k < MAX_SNOOZES - 1; k++) begin
            step(0, 0, 1, 0);
            for (int i = 0; i < SNOOZE_MINS; i++) step(1, 0, 0, 0);
        end
        check("snooze_cnt_max", {1'b0, snooze_cnt}, 4'd3);
        step(0, 0, 1, 0);
        check("extra_snooze_ring", {3'b0, ring}, 4'd1);
        check("extra_snooze_cnt", {1'b0, snooze_cnt}, 4'd3);

        // Unattended timeout, then no retrigger while match stays high.
        for (int i = 0; i < RING_TIMEOUT_MINS - 1; i++) begin
            step(1, 0, 0, 0);
            idle(1);
        end
        check("before_timeout", {3'b0, ring}, 4'd1);
        step(1, 0, 0, 0);
        check("timeout_ring_off", {3'b0, ring}, 4'd0);
        idle(5);
        check("no_retrigger", {3'b0, ring}, 4'd0);
        check("cnt_held_idle", {1'b0, snooze_cnt}, 4'd3);

        // stop + snooze together: stop wins.
        cur_r = 1'b0; idle(1);
        cur_r = 1'b1; step(0, 0, 0, 0);
        check("new_event_cnt", {1'b0, snooze_cnt}, 4'd0);
        step(0, 0, 1, 0);
        for (int i = 0; i < SNOOZE_MINS; i++) step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        check("stop_wins_ring", {3'b0, ring}, 4'd0);
        check("stop_wins_snoozing", {3'b0, snoozing}, 4'd0);
        check("stop_wins_cnt", {1'b0, snooze_cnt}, 4'd1);

        // alarm_on dropped during snooze.
        cur_r = 1'b0; idle(1);
        cur_r = 1'b1; step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("pre_drop_snoozing", {3'b0, snoozing}, 4'd1);
        cur_a = 1'b0; step(0, 0, 0, 0);
        check("drop_snoozing", {3'b0, snoozing}, 4'd0);
        check("drop_ring", {3'b0, ring}, 4'd0);
        cur_a = 1'b1; idle(1);

        // Beep pattern across sec_ticks.
        cur_r = 1'b0; idle(1);
        cur_r = 1'b1; step(0, 0, 0, 0);
        check("beep_entry", {3'b0, ring}, 4'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
`ifdef ALARM_BEEP_PATTERN_EN
            check("beep_toggle", {3'b0, ring}, (i % 2 == 0) ? 4'd0 : 4'd1);
`else
            check("beep_steady", {3'b0, ring}, 4'd1);
`endif
        end
        step(0, 0, 0, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) cur_r = ~cur_r;
            cur_a = ($urandom_range(0, 149) != 0);
            step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_ringer_ctrl.md
Name: alarm_ringer_ctrl

Overview:
- Downstream of the alarm/time comparator. Consumes its match level RINGER1 and drives the physical ringer.
- Owns the alarm session: ring, snooze, stop, timeout.
- Turns the comparator's minute-long match level into one alarm event per match.
- Purely synchronous to the timer clock. Minute and second timing comes from tick pulses supplied by the timekeeping counter.

Parameters:
- SNOOZE_MINS, 5, minutes silent after a snooze press before re-ringing (1..15)
- RING_TIMEOUT_MINS, 10, minutes of unattended ringing before auto-stop (1..15)
- MAX_SNOOZES, 3, snooze presses honoured per alarm event (0..7)

Ports:
- clk  input  1  timer clock
- reset  input  1  asynchronous, active-high reset
- alarm_on  input  1  user alarm enable switch (level)
- RINGER1  input  1  comparator match level (alarm time == current time)
- min_tick  input  1  one-cycle pulse at each minute rollover
- sec_tick  input  1  one-cycle pulse at each second rollover
- snooze  input  1  snooze request, one-cycle pulse (debounced upstream)
- stop  input  1  stop request, one-cycle pulse (debounced upstream)
- ring  output  1  ringer drive
- snoozing  output  1  high while in SNOOZE state
- snooze_cnt  output  3  snoozes used in current event

Behaviour:
- Reset (async, active-high):
  - state=IDLE; ring=0; snoozing=0; snooze_cnt=0; min counter=0.
  - match_d register=1, so a match already present at reset release does not fire.
- match_rise = RINGER1 & ~match_d; match_d <= RINGER1 every cycle.
- All outputs registered; ring asserts the cycle after the match_rise cycle (latency 1).
- States: IDLE, RINGING, SNOOZE (2-bit encoding). Per-cycle priority: alarm_on low > stop > snooze > min_tick > match_rise.
- IDLE:
  - alarm_on & match_rise -> RINGING; min counter cleared; snooze_cnt cleared.
  - Otherwise hold. ring=0.
- RINGING:
  - ring=1.
  - stop -> IDLE.
  - snooze with snooze_cnt < MAX_SNOOZES -> SNOOZE; min counter loaded with SNOOZE_MINS; snooze_cnt+1.
  - snooze with snooze_cnt == MAX_SNOOZES: ignored, ringing continues.
  - min_tick: min counter+1. When the counter reaches RING_TIMEOUT_MINS -> IDLE.
- SNOOZE:
  - ring=0; snoozing=1.
  - min_tick: min counter-1. The tick that brings it to 0 -> RINGING, with the min counter cleared for a fresh timeout window.
  - stop -> IDLE. snooze pulses ignored.
- match_rise in RINGING/SNOOZE: ignored. No restart, no counter change.
- alarm_on deasserted in any state -> IDLE next cycle; ring=0.
- snooze_cnt holds its value in IDLE until the next event starts (readable by display logic).
- Simultaneous events:
  - stop+snooze same cycle: stop wins.
  - snooze+min_tick same cycle in RINGING: snooze wins; the tick is not counted.
- Counter widths: the min counter is 4 bits, sized for the parameter ranges.

Optional Feature:
- Macro: ALARM_BEEP_PATTERN_EN.
- Defined:
  - ring = RINGING & beep_phase.
  - beep_phase sets to 1 on every RINGING entry and toggles on each sec_tick while RINGING (1 s on / 1 s off).
  - beep_phase resets to 0.
- Undefined: ring is a steady level while RINGING; no beep_phase register exists.

Decomposition:
- Shared timer package holds:
  - state typedef/localparams (ST_IDLE=0, ST_RINGING=1, ST_SNOOZE=2)
  - default SNOOZE_MINS / RING_TIMEOUT_MINS / MAX_SNOOZES constants
  - min-counter width constant
- One natural sub-module: alarm_edge_detect, holding the match_d register and match_rise generation, with reset value 1.

Test Plan:
- Reset release with RINGER1=1, alarm_on=1 -> ring stays 0. RINGER1 0->1 later -> ring=1 exactly one cycle after the rise cycle.
- Ring, then snooze pulse -> ring=0, snoozing=1, snooze_cnt=1. After 5 min_ticks -> ring=1 on the cycle after the 5th tick.
- Ring with 3 snoozes consumed -> snooze_cnt=3. 4th snooze pulse -> ring stays 1, snooze_cnt stays 3.
- Ring unattended -> after the 10th min_tick, state=IDLE and ring=0. RINGER1 held high -> no retrigger.
- stop and snooze in the same cycle during RINGING -> IDLE, snooze_cnt unchanged. alarm_on dropped during SNOOZE -> IDLE next cycle.
- With ALARM_BEEP_PATTERN_EN defined -> ring=1 at entry, toggles on each sec_tick (1,0,1,0 over 4 ticks). Undefined -> steady 1.
